// File: rtl/ifetch_buffer.sv
// Instruction fetch buffer: issues sequential ROM fetches, queues returned
// words with their byte addresses in a small prefetch FIFO, and hands them to
// decode through a valid/ready port. Redirects flush the FIFO and restart
// fetch; a misaligned redirect target parks the unit in HALT until an aligned
// redirect arrives.
module ifetch_buffer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        i_CLK,
  input  logic        i_RSTn,
  output logic        o_INSTR_REQ,
  input  logic        i_INSTR_GNT,
  output logic [31:0] o_ADDR_INSTR,
  input  logic [31:0] i_RDATA_INSTR,
  output logic        o_VALID,
  input  logic        i_READY,
  output logic [31:0] o_INSTR,
  output logic [31:0] o_PC,
  input  logic        i_REDIRECT,
  input  logic [31:0] i_REDIRECT_PC,
  output logic        o_MISALIGN
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [31:0]        fetch_pc;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic [31:0]        instr_mem [DEPTH];
  logic [31:0]        pc_mem    [DEPTH];
  logic               req;
  logic               vld;
  logic               halted;
  logic               push;
  logic               pop;
  logic               redir_misaligned;

  assign redir_misaligned = |i_REDIRECT_PC[1:0];

  // State register: synchronous active-low reset returns to IDLE
  always_ff @(posedge i_CLK) begin
    if (!i_RSTn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic: one IDLE cycle, then RUN; misaligned redirect parks in HALT
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = RUN;
      RUN:     if (i_REDIRECT && redir_misaligned)  state_nxt = HALT;
      HALT:    if (i_REDIRECT && !redir_misaligned) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: handshakes are suppressed while reset is asserted so that
  // grants/readies ignored by the control logic are never advertised as taken
  always_comb begin
    req    = i_RSTn && (state == RUN) && (count < DEPTH_C) && !i_REDIRECT;
    vld    = i_RSTn && (count != '0) && (state != HALT);
    halted = i_RSTn && (state == HALT);
  end

  // A push already excludes redirect via req; pops are blocked by redirect priority
  assign push = req && i_INSTR_GNT;
  assign pop  = vld && i_READY && !i_REDIRECT;

  // Fetch PC, pointers and occupancy; redirect wins over push and pop
  always_ff @(posedge i_CLK) begin
    if (!i_RSTn) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (i_REDIRECT) begin
      fetch_pc <= {i_REDIRECT_PC[31:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + 32'd4;
        wr_ptr   <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage: data only, never reset
  always_ff @(posedge i_CLK) begin
    if (push) begin
      instr_mem[wr_ptr] <= i_RDATA_INSTR;
      pc_mem[wr_ptr]    <= fetch_pc;
    end
  end

  assign o_INSTR_REQ  = req;
  assign o_ADDR_INSTR = i_RSTn ? fetch_pc : RESET_PC;
  assign o_VALID      = vld;
  assign o_INSTR      = instr_mem[rd_ptr];
  assign o_PC         = pc_mem[rd_ptr];
  assign o_MISALIGN   = halted;

endmodule

// File: tb/tb_ifetch_buffer.sv
// Bench for ifetch_buffer: per-cycle vector table covering startup, FIFO fill
// and drain, redirect flush, misaligned halt and address wrap, followed by a
// grant-toggling stream with a mid-stream reset. A scoreboard queues every
// granted fetch and checks it against what decode receives.
module tb_ifetch_buffer;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam int NVEC = 30;

  logic        clk;
  logic        rstn;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic        vld;
  logic        ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        redir;
  logic [31:0] rpc;
  logic        mis;

  int checks;
  int failures;

  typedef struct {
    logic        rstn;
    logic        redir;
    logic [31:0] rpc;
    logic        gnt;
    logic        ready;
    logic        req;
    logic        vld;
    logic        mis;
    logic [31:0] addr;
    logic [31:0] hpc;
  } vec_t;

  vec_t tbl [NVEC];

  ifetch_buffer #(.RESET_PC(RPC), .DEPTH(2)) dut (
    .i_CLK        (clk),
    .i_RSTn       (rstn),
    .o_INSTR_REQ  (req),
    .i_INSTR_GNT  (gnt),
    .o_ADDR_INSTR (addr),
    .i_RDATA_INSTR(rdata),
    .o_VALID      (vld),
    .i_READY      (ready),
    .o_INSTR      (instr),
    .o_PC         (pc),
    .i_REDIRECT   (redir),
    .i_REDIRECT_PC(rpc),
    .o_MISALIGN   (mis)
  );

  // ROM model: word i holds i + 0x100
  assign rdata = (addr >> 2) + 32'h100;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic rd, input logic [31:0] rp,
                              input logic g, input logic rdy, input logic q,
                              input logic v, input logic m, input logic [31:0] a,
                              input logic [31:0] hp);
    vec_t t;
    t.rstn = r; t.redir = rd; t.rpc = rp; t.gnt = g; t.ready = rdy;
    t.req = q; t.vld = v; t.mis = m; t.addr = a; t.hpc = hp;
    return t;
  endfunction

  // Scoreboard: push on grant, pop and compare on decode acceptance
  initial begin
    logic [63:0] sbq [$];
    logic [63:0] item;
    logic [31:0] exp_pc;
    exp_pc = RPC;
    forever begin
      @(negedge clk);
      if (rstn !== 1'b1) begin
        sbq.delete();
        exp_pc = RPC;
      end else if (redir) begin
        sbq.delete();
        exp_pc = {rpc[31:2], 2'b00};
      end else begin
        if (vld === 1'b1 && ready) begin
          if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_pop actual=valid_with_no_fetch expected=no_valid");
          end else begin
            item = sbq.pop_front();
            chk("sb_pc", pc, item[63:32]);
            chk("sb_instr", instr, item[31:0]);
          end
        end
        if (req === 1'b1) begin
          chk("sb_addr", addr, exp_pc);
          if (gnt) begin
            sbq.push_back({exp_pc, (exp_pc >> 2) + 32'h100});
            exp_pc = exp_pc + 32'd4;
          end
        end
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    rstn  = 1'b0;
    gnt   = 1'b1;
    ready = 1'b1;
    redir = 1'b0;
    rpc   = 32'h0;

    // vectors: rstn redir rpc gnt ready | req vld mis addr head_pc
    tbl[0]  = mk(L, L, 32'h0, H, H, L, L, L, 32'h0, 32'h0);
    tbl[1]  = mk(H, L, 32'h0, H, H, L, L, L, 32'h0, 32'h0);
    tbl[2]  = mk(H, L, 32'h0, H, H, H, L, L, 32'h0, 32'h0);
    tbl[3]  = mk(H, L, 32'h0, H, H, H, H, L, 32'h4, 32'h0);
    tbl[4]  = mk(H, L, 32'h0, H, H, H, H, L, 32'h8, 32'h4);
    tbl[5]  = mk(L, L, 32'h0, H, H, L, L, L, 32'h0, 32'h0);
    tbl[6]  = mk(H, L, 32'h0, H, L, L, L, L, 32'h0, 32'h0);
    tbl[7]  = mk(H, L, 32'h0, H, L, H, L, L, 32'h0, 32'h0);
    tbl[8]  = mk(H, L, 32'h0, H, L, H, H, L, 32'h4, 32'h0);
    tbl[9]  = mk(H, L, 32'h0, H, L, L, H, L, 32'h8, 32'h0);
    tbl[10] = mk(H, L, 32'h0, H, L, L, H, L, 32'h8, 32'h0);
    tbl[11] = mk(H, L, 32'h0, H, H, L, H, L, 32'h8, 32'h0);
    tbl[12] = mk(H, L, 32'h0, H, H, H, H, L, 32'h8, 32'h4);
    tbl[13] = mk(H, L, 32'h0, H, H, H, H, L, 32'hC, 32'h8);
    tbl[14] = mk(H, L, 32'h0, H, L, H, H, L, 32'h10, 32'hC);
    tbl[15] = mk(H, H, 32'h40, H, H, L, H, L, 32'h14, 32'hC);
    tbl[16] = mk(H, L, 32'h0, H, H, H, L, L, 32'h40, 32'h0);
    tbl[17] = mk(H, L, 32'h0, H, H, H, H, L, 32'h44, 32'h40);
    tbl[18] = mk(H, H, 32'h42, H, H, L, H, L, 32'h48, 32'h44);
    tbl[19] = mk(H, L, 32'h0, H, H, L, L, H, 32'h40, 32'h0);
    tbl[20] = mk(H, L, 32'h0, H, H, L, L, H, 32'h40, 32'h0);
    tbl[21] = mk(H, L, 32'h0, H, H, L, L, H, 32'h40, 32'h0);
    tbl[22] = mk(H, H, 32'h80, H, H, L, L, H, 32'h40, 32'h0);
    tbl[23] = mk(H, L, 32'h0, H, H, H, L, L, 32'h80, 32'h0);
    tbl[24] = mk(H, L, 32'h0, H, H, H, H, L, 32'h84, 32'h80);
    tbl[25] = mk(H, H, 32'hFFFF_FFF8, H, H, L, H, L, 32'h88, 32'h84);
    tbl[26] = mk(H, L, 32'h0, H, H, H, L, L, 32'hFFFF_FFF8, 32'h0);
    tbl[27] = mk(H, L, 32'h0, H, H, H, H, L, 32'hFFFF_FFFC, 32'hFFFF_FFF8);
    tbl[28] = mk(H, L, 32'h0, H, H, H, H, L, 32'h0, 32'hFFFF_FFFC);
    tbl[29] = mk(H, L, 32'h0, H, H, H, H, L, 32'h4, 32'h0);

    // reset state with grant/ready asserted
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_vld", {31'd0, vld}, 32'd0);
    chk("rst_mis", {31'd0, mis}, 32'd0);
    chk("rst_addr", addr, RPC);

    for (int i = 0; i < NVEC; i++) begin
      @(posedge clk);
      #1;
      rstn  = tbl[i].rstn;
      redir = tbl[i].redir;
      rpc   = tbl[i].rpc;
      gnt   = tbl[i].gnt;
      ready = tbl[i].ready;
      @(negedge clk);
      chk($sformatf("v%0d_req", i), {31'd0, req}, {31'd0, tbl[i].req});
      chk($sformatf("v%0d_vld", i), {31'd0, vld}, {31'd0, tbl[i].vld});
      chk($sformatf("v%0d_mis", i), {31'd0, mis}, {31'd0, tbl[i].mis});
      chk($sformatf("v%0d_addr", i), addr, tbl[i].addr);
      if (tbl[i].vld) begin
        chk($sformatf("v%0d_pc", i), pc, tbl[i].hpc);
        chk($sformatf("v%0d_instr", i), instr, (tbl[i].hpc >> 2) + 32'h100);
      end
    end

    // grant toggling 1,0,1,0 with random ready; scoreboard checks ordering
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      rstn  = 1'b1;
      redir = 1'b0;
      gnt   = (k % 2 == 0);
      ready = 1'($urandom_range(0, 1));
    end

    // one-cycle reset mid-stream
    @(posedge clk);
    #1;
    rstn = 1'b0;
    gnt  = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_req", {31'd0, req}, 32'd0);
    chk("mid_rst_vld", {31'd0, vld}, 32'd0);
    chk("mid_rst_addr", addr, RPC);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_idle_req", {31'd0, req}, 32'd0);
    chk("post_rst_idle_vld", {31'd0, vld}, 32'd0);
    @(negedge clk);
    chk("post_rst_req", {31'd0, req}, 32'd1);
    chk("post_rst_addr", addr, RPC);
    @(negedge clk);
    chk("post_rst_vld", {31'd0, vld}, 32'd1);
    chk("post_rst_pc", pc, RPC);
    repeat (6) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
